// File: rtl/keccak_squeeze.sv
// -----------------------------------------------------------------------------
// keccak_squeeze
//
// Squeeze-side output engine for the Keccak sponge. Captures a permuted 5x5
// lane state from the permutation core, streams the first RATE_LANES lanes
// out one per beat (lane k -> state[k mod 5][k div 5]), and hands the held
// state back for another permutation when the request outlasts one rate block.
//
// Configuration macro:
//   KECCAK_SQUEEZE_BSWAP_EN  defined: m_data carries the byte-reversed lane
//                            (lane byte 0 on m_data[w-1:w-8]).
//                            undefined: m_data carries the lane as stored.
//   p_state is never byte-swapped.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          begin a squeeze of len lanes (sampled in IDLE only)
//   s_valid/s_ready     permuted state input handshake, s_state indexed [x][y]
//   p_valid/p_ready     re-permute request, p_state is the held register
//   m_valid/m_ready     output lane stream, m_data lane, m_last final beat
//   busy                block is not idle
//   done                one-cycle pulse after the final lane handshake
// -----------------------------------------------------------------------------
module keccak_squeeze #(
  parameter int w          = 64,
  parameter int RATE_LANES = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 len,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [4:0][4:0][w-1:0]      s_state,
  output logic                        p_valid,
  input  logic                        p_ready,
  output logic [4:0][4:0][w-1:0]      p_state,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [w-1:0]                m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EMIT,
    ST_PERM,
    ST_DONE
  } state_t;

  // Rate never exceeds 24 lanes, so a 5-bit lane counter always suffices.
  localparam logic [4:0] LAST_K = 5'(RATE_LANES - 1);

  state_t                   state, state_nxt;
  logic [15:0]              remaining;
  logic [4:0]               k;
  logic [4:0][4:0][w-1:0]   held;

  logic [2:0]               lane_x;
  logic [2:0]               lane_y;
  logic [w-1:0]             lane_raw;
  logic [w-1:0]             lane_out;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    p_valid   = 1'b0;
    m_valid   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (len != 16'd0) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          // Request completion takes priority over the end of a rate block.
          if (remaining == 16'd1)  state_nxt = ST_DONE;
          else if (k == LAST_K)    state_nxt = ST_PERM;
        end
      end
      ST_PERM: begin
        p_valid = 1'b1;
        if (p_ready) state_nxt = ST_WAIT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: lane counter, remaining count, held state
  // ---------------------------------------------------------------------------
  // NOTE: the held state is deliberately reset to zero so p_state and m_data
  // read as zero out of reset; this is a register bank, not a RAM, so the
  // reset costs nothing in mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= 16'd0;
      k         <= 5'd0;
      held      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (len != 16'd0)) begin
            remaining <= len;
            k         <= 5'd0;
          end
        end
        ST_WAIT: begin
          if (s_valid) begin
            held <= s_state;
            k    <= 5'd0;
          end
        end
        ST_EMIT: begin
          if (m_ready) begin
            remaining <= remaining - 16'd1;
            k         <= k + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output lane selection
  // ---------------------------------------------------------------------------
  // Divide/modulo by the constant 5 over a 5-bit counter reduces to a tiny
  // lookup; k stays below 25 while in EMIT.
  assign lane_x   = 3'(k % 5'd5);
  assign lane_y   = 3'(k / 5'd5);
  assign lane_raw = held[lane_x][lane_y];

  always_comb begin
    lane_out = '0;
`ifdef KECCAK_SQUEEZE_BSWAP_EN
    for (int b = 0; b < w / 8; b++) begin
      lane_out[w - 8 - 8 * b +: 8] = lane_raw[8 * b +: 8];
    end
`else
    lane_out = lane_raw;
`endif
  end

  // m_data is forced to zero outside EMIT so the lane bus is quiet whenever
  // it is not carrying a valid beat.
  assign m_data  = (state == ST_EMIT) ? lane_out : '0;
  assign m_last  = (state == ST_EMIT) && (remaining == 16'd1);
  assign p_state = held;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_keccak_squeeze.sv
// -----------------------------------------------------------------------------
// tb_keccak_squeeze
//
// Self-checking bench for keccak_squeeze. A reference model tracks the phase
// of a squeeze request from the documented timing rules and predicts every
// output each cycle; the expected lane stream is computed from the list of
// state blocks presented (beat i comes from block i/17, lane i%17).
// -----------------------------------------------------------------------------
module tb_keccak_squeeze;

  localparam int W    = 64;
  localparam int RATE = 17;

  typedef logic [4:0][4:0][W-1:0] st_t;

  // Model phases of a request
  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_EMIT = 2;
  localparam int PH_PERM = 3;
  localparam int PH_DONE = 4;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         start   = 1'b0;
  logic [15:0]  len     = 16'd0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  st_t          s_state = '0;
  logic         p_valid;
  logic         p_ready = 1'b0;
  st_t          p_state;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  st_t          blk_q[$];
  bit           rdy_q[$];
  logic [W-1:0] got_q[$];
  bit           rand_mode = 1'b0;
  int           abort_at  = -1;

  always #5 clk = ~clk;

  keccak_squeeze #(.w(W), .RATE_LANES(RATE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_state (s_state),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .p_state (p_state),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
  );

  // Expected lane as it appears on m_data
  function automatic logic [W-1:0] ref_lane(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
`ifdef KECCAK_SQUEEZE_BSWAP_EN
    for (int i = 0; i < W / 8; i++) r[W - 8 - 8 * i +: 8] = v[8 * i +: 8];
`endif
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = {$urandom, $urandom};
    return r;
  endfunction

  // lane[x][y] = 0x...0xy0
  function automatic st_t pattern_state();
    st_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = 64'((x << 8) | (y << 4));
    return r;
  endfunction

  function automatic st_t fill_state(input logic [W-1:0] v);
    st_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = v;
    return r;
  endfunction

  // Drive one request of n lanes and compare every output every cycle with
  // the model. Returns early (before the handshake edge) when abort_at beats
  // have been accepted.
  task automatic run_squeeze(input int n);
    int ph;
    int idx;
    int blk;
    int cyc;
    int kk;
    bit fin;
    logic [W-1:0] exp_d;
    idx = 0; blk = 0; cyc = 0; fin = 1'b0;
    got_q.delete();
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_before_start: busy=%b expected 0", busy);
    end
    start = 1'b1;
    len   = 16'(n);
    ph    = (n == 0) ? PH_DONE : PH_WAIT;
    @(negedge clk);
    while (!fin) begin
      // start/len toggled freely while busy: they must be ignored
      start   = (ph != PH_IDLE) ? 1'($urandom % 2) : 1'b0;
      len     = 16'($urandom);
      s_valid = rand_mode ? ($urandom % 3 != 0) : 1'b1;
      p_ready = rand_mode ? ($urandom % 2 == 1) : 1'b1;
      if (ph == PH_WAIT && blk < blk_q.size()) s_state = blk_q[blk];
      else                                     s_state = rand_state();
      if (ph == PH_EMIT)
        m_ready = (rdy_q.size() != 0) ? rdy_q.pop_front()
                                      : (rand_mode ? 1'($urandom % 2) : 1'b1);
      else
        m_ready = 1'($urandom % 2);
      #1;
      n_tests++;
      if (s_ready !== (ph == PH_WAIT)) begin
        n_fail++; $display("FAIL s_ready cyc%0d: got %b expected %b", cyc, s_ready, ph == PH_WAIT);
      end
      n_tests++;
      if (m_valid !== (ph == PH_EMIT)) begin
        n_fail++; $display("FAIL m_valid cyc%0d: got %b expected %b", cyc, m_valid, ph == PH_EMIT);
      end
      n_tests++;
      if (p_valid !== (ph == PH_PERM)) begin
        n_fail++; $display("FAIL p_valid cyc%0d: got %b expected %b", cyc, p_valid, ph == PH_PERM);
      end
      n_tests++;
      if (done !== (ph == PH_DONE)) begin
        n_fail++; $display("FAIL done cyc%0d: got %b expected %b", cyc, done, ph == PH_DONE);
      end
      n_tests++;
      if (busy !== (ph != PH_IDLE)) begin
        n_fail++; $display("FAIL busy cyc%0d: got %b expected %b", cyc, busy, ph != PH_IDLE);
      end
      n_tests++;
      if (m_last !== (ph == PH_EMIT && idx == n - 1)) begin
        n_fail++; $display("FAIL m_last cyc%0d beat%0d: got %b expected %b", cyc, idx, m_last, ph == PH_EMIT && idx == n - 1);
      end
      if (ph == PH_EMIT) begin
        kk    = idx % RATE;
        exp_d = ref_lane(blk_q[idx / RATE][kk % 5][kk / 5]);
        n_tests++;
        if (m_data !== exp_d) begin
          n_fail++; $display("FAIL m_data beat%0d: got %h expected %h", idx, m_data, exp_d);
        end
      end
      if (ph == PH_PERM) begin
        n_tests++;
        if (p_state !== blk_q[blk]) begin
          n_fail++; $display("FAIL p_state block%0d: got lane00 %h expected %h", blk, p_state[0][0], blk_q[blk][0][0]);
        end
      end
      case (ph)
        PH_IDLE: fin = 1'b1;
        PH_WAIT: begin
          if (blk >= blk_q.size()) begin
            n_fail++; $display("FAIL extra_state_request: block %0d requested, only %0d provided", blk, blk_q.size());
            fin = 1'b1;
          end else if (s_valid) ph = PH_EMIT;
        end
        PH_EMIT: begin
          if (m_ready) begin
            got_q.push_back(m_data);
            idx++;
            if (idx == n)             ph = PH_DONE;
            else if (idx % RATE == 0) ph = PH_PERM;
            if (idx == abort_at)      fin = 1'b1;
          end
        end
        PH_PERM: begin
          if (p_ready) begin
            blk++;
            ph = PH_WAIT;
          end
        end
        default: ph = PH_IDLE;
      endcase
      cyc++;
      if (cyc > 5000) begin
        n_fail++; $display("FAIL timeout: request of %0d lanes, %0d beats after %0d cycles", n, idx, cyc);
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if ({s_ready, p_valid, m_valid, m_last, done, busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {s_ready, p_valid, m_valid, m_last, done, busy});
    end
    n_tests++;
    if (m_data !== '0) begin
      n_fail++; $display("FAIL reset_m_data: got %h expected 0", m_data);
    end
    n_tests++;
    if (p_state !== '0) begin
      n_fail++; $display("FAIL reset_p_state: got nonzero, lane00 %h", p_state[0][0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_short();
    rand_mode = 1'b0; abort_at = -1;
    blk_q = '{pattern_state()};
    run_squeeze(3);
    n_tests++;
    if (got_q.size() != 3) begin
      n_fail++; $display("FAIL short_beats: got %0d expected 3", got_q.size());
    end else begin
      n_tests++;
      if (got_q[0] !== ref_lane(64'h0) || got_q[1] !== ref_lane(64'h100) || got_q[2] !== ref_lane(64'h200)) begin
        n_fail++; $display("FAIL short_lanes: got %h %h %h expected lanes (0,0) (1,0) (2,0)", got_q[0], got_q[1], got_q[2]);
      end
    end
  endtask

  task automatic test_full_rate();
    rand_mode = 1'b0; abort_at = -1;
    blk_q = '{pattern_state()};
    run_squeeze(17);
    n_tests++;
    if (got_q.size() != 17) begin
      n_fail++; $display("FAIL full_rate_beats: got %0d expected 17", got_q.size());
    end else begin
      n_tests++;
      if (got_q[16] !== ref_lane(64'h130)) begin
        n_fail++; $display("FAIL full_rate_last_lane: got %h expected lane (1,3)", got_q[16]);
      end
    end
  endtask

  task automatic test_multi_block();
    rand_mode = 1'b0; abort_at = -1;
    blk_q = '{pattern_state(), fill_state(64'hA5A5_A5A5_A5A5_A5A5)};
    run_squeeze(18);
    n_tests++;
    if (got_q.size() != 18) begin
      n_fail++; $display("FAIL multi_block_beats: got %0d expected 18", got_q.size());
    end else begin
      n_tests++;
      if (got_q[17] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
        n_fail++; $display("FAIL multi_block_beat18: got %h expected a5a5a5a5a5a5a5a5", got_q[17]);
      end
    end
  endtask

  task automatic test_stall();
    rand_mode = 1'b0; abort_at = -1;
    blk_q = '{rand_state()};
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_squeeze(4);
    n_tests++;
    if (got_q.size() != 4 || rdy_q.size() != 0) begin
      n_fail++; $display("FAIL stall_handshakes: got %0d beats, %0d pattern left, expected 4 and 0", got_q.size(), rdy_q.size());
    end
    rdy_q.delete();
  endtask

  task automatic test_len_zero();
    rand_mode = 1'b0; abort_at = -1;
    blk_q.delete();
    run_squeeze(0);
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL len_zero_beats: got %0d expected 0", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    rand_mode = 1'b0; abort_at = 2;
    blk_q = '{rand_state()};
    run_squeeze(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({m_valid, m_last, busy, done, s_ready, p_valid} !== 6'b0) begin
      n_fail++; $display("FAIL midreset_flags: got %b expected 000000", {m_valid, m_last, busy, done, s_ready, p_valid});
    end
    n_tests++;
    if (m_data !== '0 || p_state !== '0) begin
      n_fail++; $display("FAIL midreset_data: m_data %h p_state lane00 %h expected 0", m_data, p_state[0][0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midreset_no_done: done %b busy %b expected 0 0", done, busy);
      end
    end
    abort_at = -1;
    blk_q = '{rand_state()};
    run_squeeze(1);
    n_tests++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL after_reset_len1: got %0d beats expected 1", got_q.size());
    end
  endtask

  task automatic test_random();
    int n;
    rand_mode = 1'b1; abort_at = -1;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 60);
      blk_q.delete();
      for (int b = 0; b < (n + RATE - 1) / RATE; b++) blk_q.push_back(rand_state());
      run_squeeze(n);
      n_tests++;
      if (got_q.size() != n) begin
        n_fail++; $display("FAIL random_len%0d_beats: got %0d expected %0d", n, got_q.size(), n);
      end
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_short();
    test_full_rate();
    test_multi_block();
    test_stall();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
